// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the IF/MEM shared-bus arbiter.
// Holds the reset level, bus widths, default limits and FSM encoding.
package bus_arbiter_pkg;

   localparam logic RST_ENABLE     = 1'b0;
   localparam int   REG_BUS        = 32;
   localparam int   DATA_ADDR_BUS  = 32;
   localparam int   TIMEOUT_DEF    = 255;
   localparam int   STARVE_LIM_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IF_BUSY  = 2'd1,
      ST_MEM_BUSY = 2'd2
   } arb_state_e;

endpackage

// File: rtl/bus_arb_wdt.sv
// Bus watchdog: counts busy cycles without a slave ack.
// Pulses expire_o on the TIMEOUT-th such cycle.
module bus_arb_wdt
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign expire_o = en_i & (cnt_q == LAST);

   // next count: clear on grant, advance while waiting
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates instruction fetch and load/store onto one bus master.
// MEM wins ties until IF has waited STARVE_LIM grants.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT    = TIMEOUT_DEF,
   parameter int STARVE_LIM = STARVE_LIM_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_ack_o,
   output logic [31:0] if_rdata_o,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   output logic        mem_ack_o,
   output logic [31:0] mem_rdata_o,
   input  logic        flush_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        stallreq_if_o,
   output logic        stallreq_mem_o,
   output logic        bus_err_o
);

   localparam logic [2:0] LIM = 3'(STARVE_LIM);

   arb_state_e  state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  starve_q, starve_d;
   logic        discard_q, discard_d;
   logic        grant;
   logic        busy;
   logic        done;
   logic        expire;
   logic        live;

   assign busy = (state_q != ST_IDLE);
   assign done = busy & (bus_ack_i | expire);
   assign live = (rst != RST_ENABLE);

   bus_arb_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (grant),
      .en_i     (busy & ~bus_ack_i),
      .expire_o (expire)
   );

   // grant decision, bus field capture and completion handling
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      sel_d     = sel_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      starve_d  = starve_q;
      discard_d = discard_q;
      grant     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            discard_d = 1'b0;
            if (mem_req_i && !(if_req_i && starve_q == LIM)) begin
               grant   = 1'b1;
               state_d = ST_MEM_BUSY;
               req_d   = 1'b1;
               we_d    = mem_we_i;
               sel_d   = mem_sel_i;
               addr_d  = mem_addr_i;
               wdata_d = mem_wdata_i;
               if (if_req_i) begin
                  starve_d = starve_q + 3'd1;
               end
            end else if (if_req_i) begin
               grant    = 1'b1;
               state_d  = ST_IF_BUSY;
               req_d    = 1'b1;
               we_d     = 1'b0;
               sel_d    = 4'b1111;
               addr_d   = if_addr_i;
               wdata_d  = '0;
               starve_d = '0;
            end
         end
         ST_IF_BUSY, ST_MEM_BUSY: begin
            if (state_q == ST_IF_BUSY && flush_i) begin
               discard_d = 1'b1;
            end
            if (done) begin
               state_d   = ST_IDLE;
               req_d     = 1'b0;
               discard_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // arbiter state and registered bus master port
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q   <= ST_IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         starve_q  <= '0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         starve_q  <= starve_d;
         discard_q <= discard_d;
      end
   end

   assign bus_req_o   = req_q;
   assign bus_we_o    = we_q;
   assign bus_sel_o   = sel_q;
   assign bus_addr_o  = addr_q;
   assign bus_wdata_o = wdata_q;

   // a reset cycle abandons the transfer, so no ack escapes it
   assign if_ack_o  = live & done & (state_q == ST_IF_BUSY)
                    & ~discard_q & ~flush_i;
   assign mem_ack_o = live & done & (state_q == ST_MEM_BUSY);
   assign bus_err_o = live & expire;

   assign if_rdata_o  = (if_ack_o & bus_ack_i) ? bus_rdata_i : '0;
   assign mem_rdata_o = (mem_ack_o & bus_ack_i) ? bus_rdata_i : '0;

   assign stallreq_if_o  = if_req_i & ~if_ack_o;
   assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
// Inputs change #1 after posedge; outputs checked #1 later.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_ack_o;
   logic [31:0] if_rdata_o;
   logic        mem_req_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_wdata_i;
   logic        mem_ack_o;
   logic [31:0] mem_rdata_o;
   logic        flush_i;
   logic        bus_req_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        stallreq_if_o;
   logic        stallreq_mem_o;
   logic        bus_err_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bus_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .if_req_i       (if_req_i),
      .if_addr_i      (if_addr_i),
      .if_ack_o       (if_ack_o),
      .if_rdata_o     (if_rdata_o),
      .mem_req_i      (mem_req_i),
      .mem_we_i       (mem_we_i),
      .mem_sel_i      (mem_sel_i),
      .mem_addr_i     (mem_addr_i),
      .mem_wdata_i    (mem_wdata_i),
      .mem_ack_o      (mem_ack_o),
      .mem_rdata_o    (mem_rdata_o),
      .flush_i        (flush_i),
      .bus_req_o      (bus_req_o),
      .bus_we_o       (bus_we_o),
      .bus_sel_o      (bus_sel_o),
      .bus_addr_o     (bus_addr_o),
      .bus_wdata_o    (bus_wdata_o),
      .bus_ack_i      (bus_ack_i),
      .bus_rdata_i    (bus_rdata_i),
      .stallreq_if_o  (stallreq_if_o),
      .stallreq_mem_o (stallreq_mem_o),
      .bus_err_o      (bus_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // MEM read that sees no ack for 254 cycles, then ack or not
   task automatic run_timeout(input logic ack_last);
      logic early;
      early       = 1'b0;
      mem_req_i   = 1'b1;
      mem_we_i    = 1'b0;
      mem_sel_i   = 4'hF;
      mem_addr_i  = 32'h2000_0000;
      bus_rdata_i = 32'hFFFF_FFFF;
      step();
      for (int i = 1; i < 255; i++) begin
         #1;
         if (mem_ack_o || bus_err_o || !bus_req_o) early = 1'b1;
         step();
      end
      chk("to_early", {31'd0, early}, 32'd0);
      bus_ack_i = ack_last;
      #1;
      chk("to_err", {31'd0, bus_err_o}, {31'd0, ~ack_last});
      chk("to_ack", {31'd0, mem_ack_o}, 32'd1);
      chk("to_rdata", mem_rdata_o,
          ack_last ? 32'hFFFF_FFFF : 32'h0);
      step();
      mem_req_i = 1'b0;
      bus_ack_i = 1'b0;
      #1;
      chk("to_req_low", {31'd0, bus_req_o}, 32'd0);
      chk("to_err_low", {31'd0, bus_err_o}, 32'd0);
   endtask

   initial begin
      rst         = 1'b0;
      if_req_i    = 1'b0;
      if_addr_i   = '0;
      mem_req_i   = 1'b0;
      mem_we_i    = 1'b0;
      mem_sel_i   = '0;
      mem_addr_i  = '0;
      mem_wdata_i = '0;
      flush_i     = 1'b0;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      step();
      step();
      #1;
      chk("rst_req", {31'd0, bus_req_o}, 32'd0);
      chk("rst_we", {31'd0, bus_we_o}, 32'd0);
      chk("rst_sel", {28'd0, bus_sel_o}, 32'd0);
      chk("rst_addr", bus_addr_o, 32'd0);
      chk("rst_wdata", bus_wdata_o, 32'd0);
      chk("rst_err", {31'd0, bus_err_o}, 32'd0);
      rst = 1'b1;
      step();

      // IF read, slave acks in the third busy cycle
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0100;
      #1;
      chk("if_stall0", {31'd0, stallreq_if_o}, 32'd1);
      step();
      chk("if_req", {31'd0, bus_req_o}, 32'd1);
      chk("if_addr", bus_addr_o, 32'h0000_0100);
      chk("if_we", {31'd0, bus_we_o}, 32'd0);
      chk("if_sel", {28'd0, bus_sel_o}, 32'hF);
      chk("if_wdata", bus_wdata_o, 32'd0);
      chk("if_stall1", {31'd0, stallreq_if_o}, 32'd1);
      chk("if_noack1", {31'd0, if_ack_o}, 32'd0);
      step();
      chk("if_stall2", {31'd0, stallreq_if_o}, 32'd1);
      step();
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'hDEAD_BEEF;
      #1;
      chk("if_ack", {31'd0, if_ack_o}, 32'd1);
      chk("if_rdata", if_rdata_o, 32'hDEAD_BEEF);
      chk("if_stall3", {31'd0, stallreq_if_o}, 32'd0);
      chk("if_req_hold", {31'd0, bus_req_o}, 32'd1);
      step();
      if_req_i  = 1'b0;
      bus_ack_i = 1'b0;
      #1;
      chk("if_req_low", {31'd0, bus_req_o}, 32'd0);
      chk("if_rdata0", if_rdata_o, 32'd0);

      // MEM store, one wait cycle
      mem_req_i   = 1'b1;
      mem_we_i    = 1'b1;
      mem_sel_i   = 4'b0011;
      mem_addr_i  = 32'h1000_0000;
      mem_wdata_i = 32'h0000_ABCD;
      step();
      chk("st_addr", bus_addr_o, 32'h1000_0000);
      chk("st_sel", {28'd0, bus_sel_o}, 32'h3);
      chk("st_wdata", bus_wdata_o, 32'h0000_ABCD);
      chk("st_we", {31'd0, bus_we_o}, 32'd1);
      chk("st_stall", {31'd0, stallreq_mem_o}, 32'd1);
      step();
      chk("st_we_hold", {31'd0, bus_we_o}, 32'd1);
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h0000_1234;
      #1;
      chk("st_ack", {31'd0, mem_ack_o}, 32'd1);
      chk("st_rdata", mem_rdata_o, 32'h0000_1234);
      chk("st_stall_ack", {31'd0, stallreq_mem_o}, 32'd0);
      step();
      mem_req_i = 1'b0;
      mem_we_i  = 1'b0;
      bus_ack_i = 1'b0;
      #1;
      chk("st_req_low", {31'd0, bus_req_o}, 32'd0);

      // both requesting, zero-wait slave: 4 MEM then 1 IF
      if_req_i   = 1'b1;
      mem_req_i  = 1'b1;
      mem_sel_i  = 4'hF;
      bus_ack_i  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("fair_mem%0d", i), {31'd0, mem_ack_o},
             (i % 5 == 4) ? 32'd0 : 32'd1);
         chk($sformatf("fair_if%0d", i), {31'd0, if_ack_o},
             (i % 5 == 4) ? 32'd1 : 32'd0);
         step();
         chk($sformatf("idle_ack%0d", i),
             {30'd0, if_ack_o, mem_ack_o}, 32'd0);
      end
      if_req_i  = 1'b0;
      mem_req_i = 1'b0;
      bus_ack_i = 1'b0;
      step();

      // flush during IF_BUSY suppresses the ack
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0200;
      step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      step();
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h5555_AAAA;
      #1;
      chk("fl_noack", {31'd0, if_ack_o}, 32'd0);
      chk("fl_rdata", if_rdata_o, 32'd0);
      step();
      bus_ack_i = 1'b0;
      flush_i   = 1'b1;
      #1;
      chk("fl_idle", {31'd0, bus_req_o}, 32'd0);
      step();
      flush_i = 1'b0;
      chk("fl_regrant", {31'd0, bus_req_o}, 32'd1);
      bus_ack_i = 1'b1;
      #1;
      chk("fl_cleared", {31'd0, if_ack_o}, 32'd1);
      chk("fl_rdata2", if_rdata_o, 32'h5555_AAAA);
      step();
      if_req_i  = 1'b0;
      bus_ack_i = 1'b0;
      step();

      // watchdog expiry, then ack colliding with expiry
      run_timeout(1'b0);
      run_timeout(1'b1);

      // reset in MEM_BUSY abandons the transfer
      mem_req_i  = 1'b1;
      mem_addr_i = 32'h3000_0000;
      step();
      chk("rb_req", {31'd0, bus_req_o}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rb_noack", {31'd0, mem_ack_o}, 32'd0);
      step();
      rst       = 1'b1;
      mem_req_i = 1'b0;
      bus_ack_i = 1'b1;
      #1;
      chk("rb_req_low", {31'd0, bus_req_o}, 32'd0);
      chk("rb_late_ack", {31'd0, mem_ack_o}, 32'd0);
      step();
      chk("rb_still_idle", {31'd0, bus_req_o}, 32'd0);
      bus_ack_i = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
